// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud arithmetic helpers
// and the ASCII control codes the echo stage reacts to.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } uart_state_t;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] ESC = 8'h1B;

  // Ceiling log2: bits needed to count 0 .. value-1.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Clock cycles per bit, rounded to nearest.
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the raw rx pin into the clock domain and filters it with a
// 3-sample majority vote taken from the synchronized value.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic vote
);

  logic [1:0] sync_q;
  logic [2:0] hist_q;

  // Everything resets to the idle (high) line level so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      hist_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], rx};
      hist_q <= {hist_q[1:0], sync_q[1]};
    end
  end

  assign rx_s = sync_q[1];
  assign vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: detects a start edge, samples each bit at its centre
// via the majority vote and emits byte strobes or frame-error strobes.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int clk_freq = 12_000_000,
  parameter int baud     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        rx_frame_err,
  output logic        rx_busy,
  output uart_state_t dbg_state
);

  localparam int BIT_CYCLES  = bit_cycles(clk_freq, baud);
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CNT_W       = log2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

  if (BIT_CYCLES < 8) begin : g_bad_baud
    $error("uart_rx_unit: clk_freq/baud gives fewer than 8 cycles per bit");
  end

  // Handshake: rx_ready is a valid-only strobe with rx_data valid in the same
  // cycle; there is no ready/backpressure, the consumer must take it then.

  uart_state_t      state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             rx_s, vote, rx_prev, fall;
  logic             bit_tick, ready_set, err_set;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .vote (vote)
  );

  assign fall      = rx_prev & ~rx_s;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (fall) state_next = S_START;
      S_START: if (cnt == HALF_LAST) state_next = vote ? S_IDLE : S_DATA;
      S_DATA:  if (cnt == BIT_LAST && idx == 3'd7) state_next = S_STOP;
      S_STOP:  if (cnt == BIT_LAST) state_next = vote ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_busy   = 1'b0;
    bit_tick  = 1'b0;
    ready_set = 1'b0;
    err_set   = 1'b0;
    rx_busy   = (state != S_IDLE);
    bit_tick  = (state == S_DATA) && (cnt == BIT_LAST);
    ready_set = (state == S_STOP) && (cnt == BIT_LAST) && vote;
    err_set   = (state == S_STOP) && (cnt == BIT_LAST) && !vote;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_ready     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_prev      <= 1'b1;
    end else begin
      rx_prev      <= rx_s;
      rx_ready     <= ready_set;
      rx_frame_err <= err_set;
      if (ready_set) rx_data <= shreg;
      // The counter restarts on every state change and at each data bit boundary.
      if (state_next != state || state == S_IDLE || state == S_BREAK || bit_tick)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (bit_tick) begin
        shreg <= {vote, shreg[7:1]};
        idx   <= idx + 3'd1;
      end else if (state == S_START) begin
        idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed plus randomized frames against a byte/latency scoreboard for uart_rx_unit.
module tb_uart_rx_unit;
  import uart_pkg::*;

  localparam int CLK_FREQ = 12_000_000;
  localparam int BAUD     = 115200;
  localparam int BITP     = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int HALFP    = BITP / 2;
  localparam int LAT      = HALFP + 9 * BITP;

  logic        clk, rst, rx;
  logic [7:0]  rx_data;
  logic        rx_ready, rx_frame_err, rx_busy;
  uart_state_t dbg_state;

  int checks, errors;
  int cyc, ready_cnt, err_cnt, both_cnt, busy_cnt;
  logic [7:0] model_last;
  logic [7:0] exp_q[$];
  int         fall_q[$];
  bit         timed_q[$];

  uart_rx_unit #(.clk_freq(CLK_FREQ), .baud(BAUD)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected byte in time.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_busy) busy_cnt++;
      if (rx_frame_err) err_cnt++;
      if (rx_ready && rx_frame_err) both_cnt++;
      if (rx_ready) begin
        ready_cnt++;
        check("ready_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          int lat;
          logic [7:0] e;
          bit t;
          e   = exp_q.pop_front();
          lat = cyc - fall_q.pop_front();
          t   = timed_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e));
          if (t) begin
            checks++;
            assert (lat >= LAT - 3 && lat <= LAT + 3) else begin
              errors++;
              $error("FAIL latency: observed %0d expected %0d+-3", lat, LAT);
            end
          end
        end
      end
    end
  end

  // Driver: one 8N1 frame with the given bit period; line is left at the stop level.
  task automatic send_byte(input logic [7:0] data, input int period, input logic stop_bit);
    if (stop_bit) begin
      exp_q.push_back(data);
      fall_q.push_back(cyc + 1);
      timed_q.push_back(period == BITP);
      model_last = data;
    end
    rx = 1'b0;
    repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (period) @(negedge clk);
    end
    rx = stop_bit;
    repeat (period) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    fall_q.delete();
    timed_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_rx_frame_err"}, 32'(rx_frame_err), 32'd0);
    check({tag, "_rx_busy"}, 32'(rx_busy), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  initial begin
    logic [7:0] bb[3];
    logic [7:0] rate_bytes[3];
    int periods[2];
    logic [7:0] aborted;
    int rdy0;
    checks = 0; errors = 0;
    ready_cnt = 0; err_cnt = 0; both_cnt = 0; busy_cnt = 0;
    model_last = 8'h00;
    bb = '{CR, LF, BS};
    rate_bytes = '{8'h00, 8'hFF, 8'hA5};
    periods = '{BITP * 97 / 100, BITP * 103 / 100};

    // Power-on reset
    rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    idle(20);

    // Single 'A'
    send_byte(8'h41, BITP, 1'b1);
    idle(10);
    wait_drain(2000);
    check("a_ready_cnt", 32'(ready_cnt), 32'd1);
    check("a_err_cnt", 32'(err_cnt), 32'd0);

    // Back-to-back control codes, no idle between frames
    for (int i = 0; i < 3; i++) send_byte(bb[i], BITP, 1'b1);
    idle(10);
    wait_drain(2000);
    check("b2b_ready_cnt", 32'(ready_cnt), 32'd4);

    // Short low glitch: busy for exactly the half-bit start check
    busy_cnt = 0;
    rdy0 = ready_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(300);
    check("glitch_busy_cycles", 32'(busy_cnt), 32'(HALFP));
    check("glitch_no_ready", 32'(ready_cnt), 32'(rdy0));
    check("glitch_no_err", 32'(err_cnt), 32'd0);

    // Bad stop bit followed by a long break
    send_byte(8'h55, BITP, 1'b0);
    repeat (3000) @(negedge clk);
    check("brk_state", 32'(dbg_state), 32'(S_BREAK));
    check("brk_err_cnt", 32'(err_cnt), 32'd1);
    check("brk_rx_data_kept", 32'(rx_data), 32'(model_last));
    check("brk_no_ready", 32'(ready_cnt), 32'(rdy0));
    idle(300);
    check("brk_released_state", 32'(dbg_state), 32'(S_IDLE));
    check("brk_err_cnt_after", 32'(err_cnt), 32'd1);
    check("brk_no_ready_after", 32'(ready_cnt), 32'(rdy0));

    // Transmitter 3% fast then 3% slow
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 3; i++) begin
        send_byte(rate_bytes[i], periods[p], 1'b1);
        idle(5);
      end
    end
    wait_drain(3000);
    check("rate_ready_cnt", 32'(ready_cnt), 32'(rdy0 + 6));

    // Random bytes, bit periods within +-3%, random gaps
    for (int i = 0; i < 8; i++) begin
      send_byte(8'($urandom_range(0, 255)), $urandom_range(BITP * 97 / 100, BITP * 103 / 100), 1'b1);
      idle($urandom_range(0, 40));
    end
    wait_drain(3000);
    check("rand_ready_cnt", 32'(ready_cnt), 32'(rdy0 + 14));
    check("rand_rx_data_last", 32'(rx_data), 32'(model_last));

    // Reset in the middle of data bit 4 of 0x3C; the transmitter gives up too
    aborted = 8'h3C;
    rdy0 = ready_cnt;
    rx = 1'b0;
    repeat (BITP) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = aborted[i];
      repeat (BITP) @(negedge clk);
    end
    rx = aborted[4];
    repeat (HALFP) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    model_last = 8'h00;
    idle(1200);
    check("midrst_no_ready", 32'(ready_cnt), 32'(rdy0));
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    send_byte(8'hC3, BITP, 1'b1);
    idle(10);
    wait_drain(2000);
    check("midrst_next_byte", 32'(rx_data), 32'hC3);
    check("midrst_ready_cnt", 32'(ready_cnt), 32'(rdy0 + 1));

    check("ready_err_never_together", 32'(both_cnt), 32'd0);
    check("final_err_cnt", 32'(err_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
